top16_reader: RTL and testbench
===============================

TOP16_READER -- requirements
Module: top16_reader

Interface
REQ-001 SHALL have parameter W, default 12, meaning the data width of each sorted slot.
REQ-002 SHALL have clk, input, 1, the single clock; all logic updates on its rising edge.
REQ-003 SHALL have synrst, input, 1, the synchronous active-high reset.
REQ-004 SHALL have SnapEn, input, 1, a load strobe for the sorted snapshot.
REQ-005 SHALL have SnapData, input, 16*W, the sorted snapshot.
- Slot k occupies bits [k*W+W-1 : k*W].
- Slot 15 holds the maximum; slots are non-increasing toward slot 0.
REQ-006 SHALL have DataValid, output, 1, the stream beat-valid signal.
REQ-007 SHALL have DataReady, input, 1, the sink ready signal.
REQ-008 SHALL have DataOut, output, W, the current beat value.
REQ-009 SHALL have DataIdx, output, 4, the beat rank (0 = maximum).
REQ-010 SHALL have DataLast, output, 1, high on the final beat of a snapshot.
REQ-011 SHALL have Busy, output, 1, high from snapshot capture until the final transfer.
REQ-012 SHALL have SumOut, output, W+4, the sum of all emitted beats.
REQ-013 SHALL have SumValid, output, 1, a one-cycle pulse qualifying SumOut.

Function
REQ-014 SHALL implement states IDLE and STREAM.
REQ-015 SHALL, in IDLE with SnapEn=1, register all of SnapData into an internal 16-entry snapshot, clear the running sum, clear DataIdx, and enter STREAM.
- Latency: DataValid=1 in the cycle after SnapEn.
REQ-016 SHALL ignore SnapEn while Busy=1, including in the cycle of the final transfer.
REQ-017 SHALL drive DataOut = snapshot slot (15 - DataIdx) whenever DataValid=1.
REQ-018 SHALL complete a transfer in any cycle with DataValid=1 and DataReady=1; on a transfer:
- DataIdx increments;
- DataOut is added to the running sum.
REQ-019 SHALL hold DataOut, DataIdx and DataLast stable while DataValid=1 and DataReady=0.
REQ-020 SHALL assert DataLast only on the final beat: DataIdx=15, or as extended by REQ-028.
REQ-021 SHALL, on the final transfer:
- return to IDLE, with DataValid=0 and Busy=0 on the next cycle;
- on that same next cycle, present the complete sum on SumOut with SumValid=1 for exactly one cycle.
REQ-022 SHALL accept a new SnapEn in the cycle SumValid=1, since the block is already in IDLE.
REQ-023 SHALL hold SumOut at its last value between pulses.
- W+4 bits hold 16*(2^W-1), so the sum never overflows.
REQ-024 SHALL support back-to-back transfers: with DataReady held at 1, 16 beats complete in 16 consecutive cycles.

Reset
REQ-025 SHALL, on synrst=1 at a clock edge, including mid-stream:
- enter IDLE;
- drive DataValid, DataLast, Busy, SumValid, DataOut, DataIdx and SumOut to 0;
- clear the snapshot to 0;
- discard any partial stream, with no SumValid pulse.
REQ-026 SHALL give synrst priority over SnapEn and over transfers in the same cycle.

Configuration
REQ-027 SHALL compile zero-skip logic only when macro TOP16_SKIPZERO_EN is defined.
REQ-028 SHALL, with TOP16_SKIPZERO_EN defined:
- end the stream at the last nonzero slot, so DataLast is high on a beat whose next-lower slot is 0;
- if slot 15 is 0, emit no beats, and produce Busy=0 and SumValid=1 with SumOut=0 two cycles after SnapEn.
REQ-029 SHALL, without TOP16_SKIPZERO_EN, always emit exactly 16 beats, including zero values.

Structure
REQ-030 SHALL place TOP_N=16, IDX_W=4 and the IDLE/STREAM state type in shared package top16_pkg.
REQ-031 SHALL implement slot selection (snapshot plus index to value) as a combinational sub-module, top16_slot_mux.

Verification
REQ-032 SHALL cover this scenario: W=12, slots 15..0 = 160,150,...,10, DataReady=1.
- Response: 16 beats 160..10 on consecutive cycles, DataIdx 0..15, DataLast on value 10, then SumOut=1360 with SumValid one cycle after.
REQ-033 SHALL cover this scenario: the same snapshot with DataReady toggling 1,0,1,0.
- Response: DataOut holds during each low cycle, no beat is lost or duplicated, and SumOut=1360.
REQ-034 SHALL cover this scenario: SnapEn with a different snapshot pulsed at beat 5 and again on the final-transfer cycle.
- Response: both pulses are ignored and the stream and sum are unchanged.
REQ-035 SHALL cover this scenario: synrst at beat 7.
- Response: next cycle all outputs are 0, no SumValid; a new SnapEn two cycles later streams from DataIdx=0.
REQ-036 SHALL cover this scenario with TOP16_SKIPZERO_EN defined: slots 15..13 = 4095,4095,1, rest 0.
- Response: 3 beats, DataLast on value 1, SumOut=8191.
- With all slots 0: no beats, and SumValid with SumOut=0 at SnapEn+2.
REQ-037 SHALL cover this scenario: all slots = 4095, DataReady=1.
- Response: SumOut=65520 (16'hFFF0), with no overflow.

Source files
------------

// File: rtl/top16_pkg.sv
// Shared definitions for the top-16 sorted snapshot reader.
//   TOP_N   : number of slots in a snapshot (16)
//   IDX_W   : width of a beat rank / slot index (4)
//   state_t : reader control states (IDLE, STREAM)
package top16_pkg;

    localparam int TOP_N = 16;
    localparam int IDX_W = 4;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

endpackage

// File: rtl/top16_slot_mux.sv
// Combinational slot selector: maps a beat rank to the snapshot slot it reads.
// Rank 0 is the maximum (slot 15), so slot = 15 - rank.
// Ports:
//   snap  : flattened snapshot, slot k at bits [k*W +: W]
//   rank  : beat rank, 0 = maximum
//   value : contents of slot (15 - rank)
module top16_slot_mux
    import top16_pkg::*;
#(
    parameter int W = 12
) (
    input  logic [TOP_N*W-1:0] snap,
    input  logic [IDX_W-1:0]   rank,
    output logic [W-1:0]       value
);

    logic [IDX_W-1:0] slot;

    always_comb begin
        slot  = IDX_W'(TOP_N - 1) - rank;
        value = snap[int'(slot)*W +: W];
    end

endmodule

// File: rtl/top16_reader.sv
// Streams a 16-entry sorted snapshot out over a valid/ready interface,
// largest value first, and reports the sum of the emitted beats.
// Optional feature: define TOP16_SKIPZERO_EN to end the stream at the last
// nonzero slot (an all-zero snapshot then emits no beats at all).
// Ports:
//   clk       : clock, rising edge
//   synrst    : synchronous active-high reset
//   SnapEn    : load strobe, honoured only while idle
//   SnapData  : sorted snapshot, slot 15 = maximum, slot k at [k*W +: W]
//   DataValid : beat valid
//   DataReady : sink ready
//   DataOut   : beat value
//   DataIdx   : beat rank (0 = maximum)
//   DataLast  : final beat of the snapshot
//   Busy      : high from capture until the final transfer
//   SumOut    : sum of all beats of the last completed stream
//   SumValid  : one-cycle pulse qualifying SumOut
module top16_reader
    import top16_pkg::*;
#(
    parameter int W = 12
) (
    input  logic               clk,
    input  logic               synrst,
    input  logic               SnapEn,
    input  logic [TOP_N*W-1:0] SnapData,
    output logic               DataValid,
    input  logic               DataReady,
    output logic [W-1:0]       DataOut,
    output logic [IDX_W-1:0]   DataIdx,
    output logic               DataLast,
    output logic               Busy,
    output logic [W+3:0]       SumOut,
    output logic               SumValid
);

    state_t             state_q, state_d;
    logic [TOP_N*W-1:0] snap_q;
    logic [IDX_W-1:0]   idx_q;
    logic [W+3:0]       sum_q;
    logic [W+3:0]       sum_next;
    logic [W+3:0]       sum_out_q;
    logic               sum_valid_q;
    logic [W-1:0]       slot_val;
    logic               empty;
    logic               last_beat;
    logic               load;
    logic               transfer;
    logic               finish;

    top16_slot_mux #(.W(W)) u_cur_slot (
        .snap  (snap_q),
        .rank  (idx_q),
        .value (slot_val)
    );

`ifdef TOP16_SKIPZERO_EN
    logic [IDX_W-1:0] idx_next;
    logic [W-1:0]     next_val;

    assign idx_next = idx_q + IDX_W'(1);

    top16_slot_mux #(.W(W)) u_next_slot (
        .snap  (snap_q),
        .rank  (idx_next),
        .value (next_val)
    );

    // Slots never increase toward slot 0, so the first zero ends the stream;
    // a zero maximum means there is nothing to emit.
    assign empty     = (idx_q == '0) && (slot_val == '0);
    assign last_beat = (idx_q == IDX_W'(TOP_N - 1)) || (next_val == '0);
`else
    assign empty     = 1'b0;
    assign last_beat = (idx_q == IDX_W'(TOP_N - 1));
`endif

    // Zero-extension cannot overflow: W+4 bits hold 16*(2^W-1).
    assign sum_next = sum_q + {4'b0000, slot_val};

    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d   = state_q;
        load      = 1'b0;
        transfer  = 1'b0;
        finish    = 1'b0;
        Busy      = (state_q == STREAM);
        DataValid = (state_q == STREAM) && !empty;
        DataOut   = '0;
        DataLast  = 1'b0;
        case (state_q)
            IDLE: begin
                if (SnapEn) begin
                    load    = 1'b1;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                DataOut  = DataValid ? slot_val : '0;
                DataLast = DataValid && last_beat;
                if (empty) begin
                    finish  = 1'b1;
                    state_d = IDLE;
                end else if (DataReady) begin
                    transfer = 1'b1;
                    if (last_beat) begin
                        finish  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (synrst) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // NOTE: the snapshot is an ordinary register bank and is cleared on reset
    // so DataOut reads 0 afterwards rather than stale data.
    always_ff @(posedge clk) begin
        if (synrst) begin
            snap_q      <= '0;
            idx_q       <= '0;
            sum_q       <= '0;
            sum_out_q   <= '0;
            sum_valid_q <= 1'b0;
        end else begin
            sum_valid_q <= 1'b0;
            if (load) begin
                snap_q <= SnapData;
                idx_q  <= '0;
                sum_q  <= '0;
            end
            if (transfer) begin
                idx_q <= idx_q + IDX_W'(1);
                sum_q <= sum_next;
            end
            if (finish) begin
                // An empty snapshot finishes without a transfer; sum_q is 0 then.
                sum_out_q   <= transfer ? sum_next : sum_q;
                sum_valid_q <= 1'b1;
            end
        end
    end

    assign DataIdx  = idx_q;
    assign SumOut   = sum_out_q;
    assign SumValid = sum_valid_q;

endmodule

// File: tb/tb_top16_reader.sv
// Scoreboard bench for top16_reader: the driver pushes the expected beats and
// sum of each snapshot into queues; a negedge monitor compares every presented
// beat and sum pulse against the queue heads.
module tb_top16_reader;
    import top16_pkg::*;

    localparam int W  = 12;
    localparam int SW = W + 4;

    logic               clk = 1'b0;
    logic               synrst;
    logic               SnapEn;
    logic [TOP_N*W-1:0] SnapData;
    logic               DataValid;
    logic               DataReady;
    logic [W-1:0]       DataOut;
    logic [IDX_W-1:0]   DataIdx;
    logic               DataLast;
    logic               Busy;
    logic [SW-1:0]      SumOut;
    logic               SumValid;

    top16_reader #(.W(W)) dut (
        .clk       (clk),
        .synrst    (synrst),
        .SnapEn    (SnapEn),
        .SnapData  (SnapData),
        .DataValid (DataValid),
        .DataReady (DataReady),
        .DataOut   (DataOut),
        .DataIdx   (DataIdx),
        .DataLast  (DataLast),
        .Busy      (Busy),
        .SumOut    (SumOut),
        .SumValid  (SumValid)
    );

    always #5 clk = ~clk;

    typedef struct {
        int value;
        int idx;
        bit last;
    } beat_t;

    beat_t beat_q[$];
    int    sum_q[$];
    int    slots[TOP_N];
    int    checks     = 0;
    int    passes     = 0;
    int    cyc        = 0;
    int    beats_seen = 0;
    int    sums_seen  = 0;
    int    sum_cyc    = 0;
    int    snap_cyc   = 0;
    int    rdy_mode   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Sink readiness: 0 = always ready, 1 = toggle each cycle, 2 = random.
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       DataReady = 1'b1;
            1:       DataReady = ~DataReady;
            default: DataReady = 1'($urandom_range(0, 1));
        endcase
    end

    // Reference model: beats are the slots read from the maximum down, each
    // tagged with its rank; the sum is the plain total of what was emitted.
    function automatic int model_push();
        int total = 0;
        int n     = 0;
        for (int r = 0; r < TOP_N; r++) begin
            int v = slots[TOP_N-1-r];
`ifdef TOP16_SKIPZERO_EN
            if (v == 0) break;
`endif
            beat_q.push_back('{v, r, 1'b0});
            total += v;
            n++;
        end
        if (n > 0) beat_q[beat_q.size()-1].last = 1'b1;
        sum_q.push_back(total);
        return n;
    endfunction

    function automatic logic [TOP_N*W-1:0] pack_slots();
        logic [TOP_N*W-1:0] d = '0;
        for (int k = 0; k < TOP_N; k++) d[k*W +: W] = W'(slots[k]);
        return d;
    endfunction

    task automatic rand_slots();
        for (int k = 0; k < TOP_N; k++)
            slots[k] = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, (1 << W) - 1));
        for (int i = 1; i < TOP_N; i++) begin
            int v = slots[i];
            int j = i - 1;
            while (j >= 0 && slots[j] > v) begin
                slots[j+1] = slots[j];
                j--;
            end
            slots[j+1] = v;
        end
    endtask

    // Monitor: compare whatever the DUT presents against the queue heads.
    always @(negedge clk) begin
        if (!synrst) begin
            if (DataValid) begin
                check("beat_pending", beat_q.size() > 0, 1);
                if (beat_q.size() > 0) begin
                    check("DataOut", DataOut, beat_q[0].value);
                    check("DataIdx", DataIdx, beat_q[0].idx);
                    check("DataLast", DataLast, beat_q[0].last);
                    check("Busy_streaming", Busy, 1);
                    if (DataReady) begin
                        void'(beat_q.pop_front());
                        beats_seen++;
                    end
                end
            end
            if (SumValid) begin
                check("sum_pending", sum_q.size() > 0, 1);
                if (sum_q.size() > 0) begin
                    check("SumOut", SumOut, sum_q.pop_front());
                    check("Busy_at_sum", Busy, 0);
                end
                sum_cyc = cyc;
                sums_seen++;
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (Busy && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("idle_timeout", Busy, 0);
    endtask

    task automatic wait_beats(input int target);
        int n = 0;
        while (beats_seen < target && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("beat_timeout", beats_seen >= target, 1);
    endtask

    task automatic wait_sum(input int target);
        int n = 0;
        while (sums_seen < target && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        check("sum_timeout", sums_seen >= target, 1);
    endtask

    task automatic issue(output int nbeats);
        wait_idle();
        SnapData = pack_slots();
        SnapEn   = 1'b1;
        nbeats   = model_push();
        @(posedge clk); #1;
        SnapEn   = 1'b0;
        snap_cyc = cyc;
        check("Busy_after_snap", Busy, 1);
        check("DataValid_latency", DataValid, nbeats > 0);
    endtask

    // With the sink always ready a stream of n beats finishes n cycles after
    // capture; an empty one finishes one cycle after capture.
    task automatic run(input int mode, input bit timed);
        int nb;
        int target;
        rdy_mode = mode;
        target   = sums_seen + 1;
        issue(nb);
        wait_sum(target);
        if (timed) check("stream_cycles", sum_cyc - snap_cyc, (nb == 0) ? 1 : nb);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_DataValid"}, DataValid, 0);
        check({tag, "_DataLast"},  DataLast, 0);
        check({tag, "_Busy"},      Busy, 0);
        check({tag, "_SumValid"},  SumValid, 0);
        check({tag, "_DataOut"},   DataOut, 0);
        check({tag, "_DataIdx"},   DataIdx, 0);
        check({tag, "_SumOut"},    SumOut, 0);
    endtask

    initial begin
        int nb;
        int base;
        int target;

        synrst    = 1'b1;
        SnapEn    = 1'b0;
        SnapData  = '0;
        DataReady = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        synrst = 1'b0;
        @(posedge clk); #1;

        // Descending 160..10, sink always ready: 16 back-to-back beats, sum 1360.
        for (int k = 0; k < TOP_N; k++) slots[k] = 10 * (k + 1);
        run(0, 1);

        // Same snapshot with ready toggling.
        run(1, 0);

        // SnapEn pulses at beat 5 and on the final-transfer cycle are ignored.
        rdy_mode = 0;
        target   = sums_seen + 1;
        base     = beats_seen;
        issue(nb);
        wait_beats(base + 5);
        SnapData = {TOP_N{W'(7)}};
        SnapEn   = 1'b1;
        @(posedge clk); #1;
        SnapEn   = 1'b0;
        wait_beats(base + 15);
        SnapEn   = 1'b1;
        @(posedge clk); #1;
        SnapEn   = 1'b0;
        wait_sum(target);
        check("pulse_stream_cycles", sum_cyc - snap_cyc, nb);
        repeat (3) @(posedge clk);
        #1;
        check("pulse_not_loaded", Busy, 0);

        // Reset at beat 7 discards the stream; restart two cycles later.
        base = beats_seen;
        issue(nb);
        wait_beats(base + 7);
        synrst = 1'b1;
        @(posedge clk); #1;
        synrst = 1'b0;
        beat_q.delete();
        sum_q.delete();
        check_zero("midreset");
        @(posedge clk); #1;
        run(0, 1);

        // Reset wins over a simultaneous SnapEn.
        wait_idle();
        synrst = 1'b1;
        SnapEn = 1'b1;
        @(posedge clk); #1;
        synrst = 1'b0;
        SnapEn = 1'b0;
        check_zero("rst_vs_snap");
        @(posedge clk); #1;
        check("rst_vs_snap_idle", Busy, 0);

        // All slots at full scale: sum 65520 without overflow.
        for (int k = 0; k < TOP_N; k++) slots[k] = (1 << W) - 1;
        run(0, 1);

        // Trailing zeros: 4095, 4095, 1, then zeros.
        for (int k = 0; k < TOP_N; k++) slots[k] = 0;
        slots[15] = 4095;
        slots[14] = 4095;
        slots[13] = 1;
        run(0, 1);
        run(2, 0);

        // All-zero snapshot.
        for (int k = 0; k < TOP_N; k++) slots[k] = 0;
        run(0, 1);

        // Randomized sorted snapshots under all sink behaviours.
        for (int i = 0; i < 40; i++) begin
            int mode;
            mode = int'($urandom_range(0, 2));
            rand_slots();
            run(mode, mode == 0);
        end

        rdy_mode = 0;
        repeat (30) @(posedge clk);
        #1;
        check("beats_drained", beat_q.size(), 0);
        check("sums_drained", sum_q.size(), 0);
        check("final_idle", DataValid, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
